my_pipelined_leftshifter: RTL and testbench
===========================================

Name: my_pipelined_leftshifter

Overview:
- Pipelined logical left barrel shifter for the ALU's sll path; it is the left-direction counterpart of the ALU's fixed right-shift stages.
- Variable shift amount 0..DATA_WIDTH-1, decomposed into binary-weighted stages of 16/8/4/2/1 positions.
- Each stage is registered. The block sustains one operation per cycle, and stall/flush hooks let it sit inside the execute stage of the processor pipeline.

Parameters:
- DATA_WIDTH, 32, operand width; must be a power of two.
- SHAMT_WIDTH, 5, shift-amount width; equals log2(DATA_WIDTH) and also sets the stage count and latency.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  data_input/shamt valid this cycle.
- data_input  input  DATA_WIDTH  operand to shift.
- shamt  input  SHAMT_WIDTH  unsigned shift amount.
- stall  input  1  freeze all pipeline registers.
- flush  input  1  kill all in-flight operations.
- out_valid  output  1  data_output holds a completed result.
- data_output  output  DATA_WIDTH  shifted result.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset state: while reset_n=0, every stage data register, stage shamt register and stage valid bit clears to 0. out_valid=0 and data_output=0 from reset assertion onward.
- Stages: stages s=0..SHAMT_WIDTH-1. Stage s consumes shamt bit (SHAMT_WIDTH-1-s), MSB first.
  - Bit set: shift left by 2^(SHAMT_WIDTH-1-s) with zero fill into the LSBs; bits shifted past the MSB are discarded.
  - Bit clear: data passes through unchanged.
  - Each stage registers data, the remaining shamt bits and a valid bit.
- Latency: exactly SHAMT_WIDTH cycles (5 at default) from an accepted input to out_valid=1. data_output and out_valid come straight from the last stage register.
- Throughput: one operation per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- Acceptance: an input is accepted on a clock edge with in_valid=1, stall=0, flush=0.
  - in_valid=0 inserts a bubble: valid bit 0, data register still loads. Downstream must qualify on out_valid.
- stall=1: every register, valid bits included, holds its value. Inputs are ignored (not accepted). out_valid and data_output stay stable for the whole stall.
- flush=1: all valid bits clear on that edge, whether or not stall is also asserted (flush has priority over stall). The current input is not accepted. Data registers may hold stale values.
- shamt=0: result equals data_input after full latency; there is no early-out path.
- Maximum shift: shamt=DATA_WIDTH-1 leaves only bit 0 of the input, moved into the MSB.
- Reset mid-operation: all in-flight operations are discarded with no partial outputs. After reset_n deasserts, the first valid output appears SHAMT_WIDTH cycles after the first accepted input.
- No combinational path from any input to any output.

Optional Feature:
- Macro MY_LEFTSHIFT_ROTATE_EN.
- Defined: adds input port rotate (1 bit), sampled with the operand and carried down the pipe with valid. When rotate=1, every active stage rotates left, feeding the discarded MSBs into the LSBs. rotate=0 behaves exactly like a logical shift.
- Undefined: no rotate port; zero fill only.
- Latency, stall and flush behaviour are identical in both builds.

Decomposition:
- Shared package my_alu_pkg:
  - DATA_WIDTH and SHAMT_WIDTH defaults.
  - Stage-weight function (2^(SHAMT_WIDTH-1-s)).
  - A struct/bundle typedef for the stage register: data, remaining shamt, valid, and rotate when enabled.
- Sub-module my_leftshift_stage:
  - One conditional constant-distance shift plus its register slice, with stall/flush/reset handling.
  - Parameterised by SHIFT_DIST.
  - The top generates SHAMT_WIDTH instances.

Test Plan:
- Reset with pipe full: issue 5 back-to-back inputs, assert reset_n=0 mid-flight, release -> out_valid=0 and data_output=0 during reset; no stale result appears afterward.
- Single op: data_input=0x00000001, shamt=31 -> exactly 5 cycles later out_valid=1, data_output=0x80000000. Also 0xFFFFFFFF, shamt=4 -> 0xFFFFFFF0.
- Streaming: 32 consecutive ops with data 0xA5A5A5A5 and shamt 0..31 -> 32 consecutive out_valid cycles in order, each equal to (0xA5A5A5A5<<k) truncated to 32 bits; the shamt=0 result is 0xA5A5A5A5.
- Stall: stall=1 for 3 cycles while 3 ops are in flight -> outputs frozen during the stall; results emerge 3 cycles late, in order, with values unchanged.
- Flush and stall+flush: assert flush (alone, and again together with stall) with 4 ops in flight -> no out_valid for those ops; an op accepted the cycle after flush returns correctly 5 cycles later.
- Rotate (macro defined): 0x80000001, shamt=1, rotate=1 -> 0x00000003; same input with rotate=0 -> 0x00000002.

Source files
------------

// File: rtl/my_alu_pkg.sv
// rtl/my_alu_pkg.sv - shared widths, stage weights and stage register bundle for the ALU shifters
// Optional rotate field controlled by MY_LEFTSHIFT_ROTATE_EN.
package my_alu_pkg;

  localparam int ALU_DATA_WIDTH  = 32;
  localparam int ALU_SHAMT_WIDTH = 5;

  // Stage s handles shamt bit (shamt_width-1-s), so the heaviest shift comes first.
  function automatic int stage_weight(input int s, input int shamt_width);
    return 1 << (shamt_width - 1 - s);
  endfunction

  typedef struct packed {
    logic [ALU_DATA_WIDTH-1:0]  data;
    logic [ALU_SHAMT_WIDTH-1:0] shamt;
`ifdef MY_LEFTSHIFT_ROTATE_EN
    logic                       rotate;
`endif
    logic                       valid;
  } stage_reg_t;

endpackage

// File: rtl/my_leftshift_stage.sv
// rtl/my_leftshift_stage.sv - one registered conditional left shift by SHIFT_DIST
// Rotate input/output exist only with MY_LEFTSHIFT_ROTATE_EN.
module my_leftshift_stage
  import my_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = ALU_SHAMT_WIDTH,
  parameter int SHIFT_DIST  = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
`ifdef MY_LEFTSHIFT_ROTATE_EN
  input  logic                   in_rotate,
  output logic                   out_rotate,
`endif
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [SHAMT_WIDTH-1:0] out_shamt
);

  localparam int BIT_IDX = $clog2(SHIFT_DIST);

  logic [DATA_WIDTH-1:0]  shifted;
  logic [SHAMT_WIDTH-1:0] remaining;

  always_comb begin
    shifted = in_data;
    if (in_shamt[BIT_IDX]) begin
`ifdef MY_LEFTSHIFT_ROTATE_EN
      if (in_rotate)
        shifted = (in_data << SHIFT_DIST) | (in_data >> (DATA_WIDTH - SHIFT_DIST));
      else
        shifted = in_data << SHIFT_DIST;
`else
      shifted = in_data << SHIFT_DIST;
`endif
    end
    remaining          = in_shamt;
    remaining[BIT_IDX] = 1'b0;
  end

  // Flush wins over stall so a frozen pipe can still be emptied.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_shamt  <= '0;
`ifdef MY_LEFTSHIFT_ROTATE_EN
      out_rotate <= 1'b0;
`endif
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (!stall) begin
      out_valid  <= in_valid;
      out_data   <= shifted;
      out_shamt  <= remaining;
`ifdef MY_LEFTSHIFT_ROTATE_EN
      out_rotate <= in_rotate;
`endif
    end
  end

endmodule

// File: rtl/my_pipelined_leftshifter.sv
// rtl/my_pipelined_leftshifter.sv - SHAMT_WIDTH-stage pipelined logical left barrel shifter
// Define MY_LEFTSHIFT_ROTATE_EN to add the rotate input.
module my_pipelined_leftshifter
  import my_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = ALU_SHAMT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  data_input,
  input  logic [SHAMT_WIDTH-1:0] shamt,
`ifdef MY_LEFTSHIFT_ROTATE_EN
  input  logic                   rotate,
`endif
  input  logic                   stall,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  data_output
);

  // Index 0 is the input side; index SHAMT_WIDTH is the last stage register.
  logic                   pipe_valid [SHAMT_WIDTH+1];
  logic [DATA_WIDTH-1:0]  pipe_data  [SHAMT_WIDTH+1];
  logic [SHAMT_WIDTH-1:0] pipe_shamt [SHAMT_WIDTH+1];
`ifdef MY_LEFTSHIFT_ROTATE_EN
  logic                   pipe_rot   [SHAMT_WIDTH+1];
`endif

  assign pipe_valid[0] = in_valid;
  assign pipe_data[0]  = data_input;
  assign pipe_shamt[0] = shamt;
`ifdef MY_LEFTSHIFT_ROTATE_EN
  assign pipe_rot[0]   = rotate;
`endif

  for (genvar s = 0; s < SHAMT_WIDTH; s++) begin : g_stage
    my_leftshift_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHAMT_WIDTH (SHAMT_WIDTH),
      .SHIFT_DIST  (stage_weight(s, SHAMT_WIDTH))
    ) u_stage (
      .clock      (clock),
      .reset_n    (reset_n),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (pipe_valid[s]),
      .in_data    (pipe_data[s]),
      .in_shamt   (pipe_shamt[s]),
`ifdef MY_LEFTSHIFT_ROTATE_EN
      .in_rotate  (pipe_rot[s]),
      .out_rotate (pipe_rot[s+1]),
`endif
      .out_valid  (pipe_valid[s+1]),
      .out_data   (pipe_data[s+1]),
      .out_shamt  (pipe_shamt[s+1])
    );
  end

  assign out_valid   = pipe_valid[SHAMT_WIDTH];
  assign data_output = pipe_data[SHAMT_WIDTH];

  // Every shamt bit has been consumed by the last stage; its copy has no reader.
  logic unused_tail;
`ifdef MY_LEFTSHIFT_ROTATE_EN
  assign unused_tail = ^{pipe_shamt[SHAMT_WIDTH], pipe_rot[SHAMT_WIDTH]};
`else
  assign unused_tail = ^pipe_shamt[SHAMT_WIDTH];
`endif

endmodule

// File: tb/tb_my_pipelined_leftshifter.sv
// tb/tb_my_pipelined_leftshifter.sv - directed self-checking bench for my_pipelined_leftshifter
// Rotate vectors are added when MY_LEFTSHIFT_ROTATE_EN is defined.
module tb_my_pipelined_leftshifter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] data_input;
  logic [4:0]  shamt;
  logic        rotate;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] data_output;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  my_pipelined_leftshifter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .data_input  (data_input),
    .shamt       (shamt),
`ifdef MY_LEFTSHIFT_ROTATE_EN
    .rotate      (rotate),
`endif
    .stall       (stall),
    .flush       (flush),
    .out_valid   (out_valid),
    .data_output (data_output)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic        rot;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] s,
                      input logic st, input logic fl, input logic rot);
    in_valid   = v;
    data_input = d;
    shamt      = s;
    stall      = st;
    flush      = fl;
    rotate     = rot;
    tick();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic ev, input logic [31:0] ed);
    checks++;
    if (out_valid !== ev || (ev && data_output !== ed)) begin
      errors++;
      $display("FAIL %s: got out_valid=%0b data_output=%08h, want out_valid=%0b data_output=%08h",
               name, out_valid, data_output, ev, ed);
    end
  endtask

  task automatic chk_exact(input string name, input logic ev, input logic [31:0] ed);
    checks++;
    if (out_valid !== ev || data_output !== ed) begin
      errors++;
      $display("FAIL %s: got out_valid=%0b data_output=%08h, want out_valid=%0b data_output=%08h",
               name, out_valid, data_output, ev, ed);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Single op on an empty pipe with a 5-cycle latency check on both sides of the result.
  task automatic single_op(input string name, input vec_t v);
    step(1'b1, v.d, v.s, 1'b0, 1'b0, v.rot);
    for (int k = 1; k <= 3; k++) begin
      idle();
      chk({name, "_early"}, 1'b0, 32'h0);
    end
    idle();
    chk(name, 1'b1, v.exp);
    idle();
    chk({name, "_after"}, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] eq[$];
    logic [31:0] a5;
    int got, first, last;

    vq.push_back('{d: 32'h0000_0001, s: 5'd31, rot: 1'b0, exp: 32'h8000_0000});
    vq.push_back('{d: 32'hFFFF_FFFF, s: 5'd4,  rot: 1'b0, exp: 32'hFFFF_FFF0});
    vq.push_back('{d: 32'h1234_5678, s: 5'd0,  rot: 1'b0, exp: 32'h1234_5678});
    vq.push_back('{d: 32'h8000_0001, s: 5'd1,  rot: 1'b0, exp: 32'h0000_0002});
    vq.push_back('{d: 32'hDEAD_BEEF, s: 5'd16, rot: 1'b0, exp: 32'hBEEF_0000});
    vq.push_back('{d: 32'hDEAD_BEEF, s: 5'd8,  rot: 1'b0, exp: 32'hADBE_EF00});
    vq.push_back('{d: 32'hF0F0_F0F1, s: 5'd31, rot: 1'b0, exp: 32'h8000_0000});
    vq.push_back('{d: 32'h0000_0003, s: 5'd21, rot: 1'b0, exp: 32'h0060_0000});
`ifdef MY_LEFTSHIFT_ROTATE_EN
    vq.push_back('{d: 32'h8000_0001, s: 5'd1,  rot: 1'b1, exp: 32'h0000_0003});
    vq.push_back('{d: 32'hDEAD_BEEF, s: 5'd16, rot: 1'b1, exp: 32'hBEEF_DEAD});
    vq.push_back('{d: 32'h1234_5678, s: 5'd31, rot: 1'b1, exp: 32'h091A_2B3C});
`endif

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    data_input = 32'h0;
    shamt      = 5'd0;
    rotate     = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    tick();
    tick();
    chk_exact("reset_state", 1'b0, 32'h0);
    reset_n = 1'b1;
    idle();
    chk_exact("post_reset_idle", 1'b0, 32'h0);

    foreach (vq[i]) single_op($sformatf("vec%0d", i), vq[i]);

    // Streaming: 32 back-to-back ops must come out as 32 consecutive results.
    a5 = 32'hA5A5_A5A5;
    got = 0; first = -1; last = -1;
    for (int t = 0; t < 44; t++) begin
      if (t < 32) begin
        step(1'b1, a5, t[4:0], 1'b0, 1'b0, 1'b0);
        eq.push_back(a5 << t);
      end else begin
        idle();
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = t;
        last = t;
        got++;
        if (eq.size() == 0) begin
          chk_int("stream_extra", 1, 0);
        end else begin
          chk($sformatf("stream%0d", got - 1), 1'b1, eq.pop_front());
        end
      end
    end
    chk_int("stream_count", got, 32);
    chk_int("stream_first", first, 4);
    chk_int("stream_no_gaps", last - first, 31);

    // Stall with the oldest of 3 ops sitting at the output.
    step(1'b1, 32'h0000_000F, 5'd4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0001, 5'd9, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE_F00D, 5'd12, 1'b0, 1'b0, 1'b0);
    idle();
    chk("stall_pre", 1'b0, 32'h0);
    idle();
    chk("stall_first", 1'b1, 32'h0000_00F0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b0, 1'b0);
      chk_exact($sformatf("stall_hold%0d", k), 1'b1, 32'h0000_00F0);
    end
    idle();
    chk("stall_second", 1'b1, 32'h0000_0200);
    idle();
    chk("stall_third", 1'b1, 32'hEF00_D000);
    for (int k = 0; k < 5; k++) begin
      idle();
      chk($sformatf("stall_drain%0d", k), 1'b0, 32'h0);
    end

    // Flush alone, then flush together with stall; both kill 4 in-flight ops.
    for (int mode = 0; mode < 2; mode++) begin
      for (int k = 0; k < 4; k++)
        step(1'b1, 32'h1111_1111 << k, 5'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h7777_7777, 5'd2, mode[0], 1'b1, 1'b0);
      chk($sformatf("flush%0d_kill", mode), 1'b0, 32'h0);
      step(1'b1, 32'h0000_00AB, 5'd8, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        idle();
        chk($sformatf("flush%0d_quiet%0d", mode, k), 1'b0, 32'h0);
      end
      idle();
      chk($sformatf("flush%0d_next", mode), 1'b1, 32'h0000_AB00);
      idle();
      chk($sformatf("flush%0d_after", mode), 1'b0, 32'h0);
    end

    // Reset with the pipe full and a result already on the output.
    for (int k = 0; k < 5; k++)
      step(1'b1, 32'h1 << k, 5'd1, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_result", 1'b1, 32'h0000_0002);
    reset_n = 1'b0;
    #1;
    chk_exact("rst_async_clear", 1'b0, 32'h0);
    idle();
    chk_exact("rst_held0", 1'b0, 32'h0);
    idle();
    chk_exact("rst_held1", 1'b0, 32'h0);
    reset_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      idle();
      chk($sformatf("rst_no_stale%0d", k), 1'b0, 32'h0);
    end
    single_op("rst_first_op", '{d: 32'h0000_0003, s: 5'd2, rot: 1'b0, exp: 32'h0000_000C});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
